// File: rtl/rsa_job_scheduler.sv
// Round-robin scheduler sharing one RSA control core between NREQ requesters:
// accepts a job, sequences core reset/start, waits for finish, returns the result.
module rsa_job_scheduler #(
    parameter int unsigned WIDTH          = 256,
    parameter int unsigned NREQ           = 2,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_mode,
    input  logic [NREQ*WIDTH-1:0]  req_msg,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [WIDTH-1:0]       rsp_msg,
    output logic                   rsp_err,
    output logic                   core_reset,
    output logic                   core_start,
    output logic                   core_mode,
    output logic [WIDTH-1:0]       core_msg_in,
    input  logic [WIDTH-1:0]       core_msg_out,
    input  logic                   core_finish
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = $clog2(SETUP_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        SETUP,
        START,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic            armed;
    logic [SW-1:0]   setup_cnt;
    logic [TW-1:0]   wait_cnt;

    logic [NREQ-1:0]  grant_c;
    logic [IW-1:0]    grant_idx_c;
    logic             grant_any_c;
    logic [WIDTH-1:0] sel_msg_c;
    int unsigned      idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        idx         = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!grant_any_c && req_valid[IW'(idx)]) begin
                grant_any_c = 1'b1;
                grant_idx_c = IW'(idx);
            end
        end
        grant_c[grant_idx_c] = grant_any_c;
    end

    always_comb begin
        sel_msg_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx_c == IW'(i)) begin
                sel_msg_c = req_msg[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (state == IDLE) ? grant_c : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IW'(NREQ - 1);
            owner       <= '0;
            armed       <= 1'b0;
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= '0;
            rsp_msg     <= '0;
            rsp_err     <= 1'b0;
            core_reset  <= 1'b0;
            core_start  <= 1'b0;
            core_mode   <= 1'b0;
            core_msg_in <= '0;
        end else begin
            core_reset <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any_c) begin
                        core_mode   <= req_mode[grant_idx_c];
                        core_msg_in <= sel_msg_c;
                        owner       <= grant_idx_c;
                        last        <= grant_idx_c;
                        core_reset  <= 1'b1;
                        state       <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    setup_cnt <= '0;
                    state     <= SETUP;
                end
                SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        core_start <= 1'b1;
                        state      <= START;
                    end else begin
                        setup_cnt <= setup_cnt + SW'(1);
                    end
                end
                START: begin
                    armed    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A finish already high at START belongs to the previous job.
                    if (!core_finish) begin
                        armed <= 1'b1;
                    end
                    if (core_finish && armed) begin
                        rsp_msg   <= core_msg_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_msg   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NREQ'(1) << owner;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench for rsa_job_scheduler with a small behavioural model of the RSA core.
module tb_rsa_job_scheduler;

    localparam int unsigned W = 256;
    localparam logic [W-1:0] M0 = 256'h48656c6c6f20576f726c6421;
    localparam logic [W-1:0] M1 = 256'h0123456789abcdef;
    localparam logic [W-1:0] M2 = 256'hcafef00d5555aaaa;
    localparam logic [W-1:0] FF = 256'hff;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [2*W-1:0] req_msg;
    logic [W-1:0]   rsp_msg, core_msg_in;
    logic [W-1:0]   core_msg_out = '0;
    logic           rsp_err, core_reset, core_start, core_mode;
    logic           core_finish = 1'b0;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;
    int lo_at = 1;
    int hi_at = 20;
    int mcnt = 0;

    rsa_job_scheduler #(
        .WIDTH(256), .NREQ(2), .SETUP_CYCLES(100), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_msg(req_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg), .rsp_err(rsp_err),
        .core_reset(core_reset), .core_start(core_start), .core_mode(core_mode),
        .core_msg_in(core_msg_in), .core_msg_out(core_msg_out), .core_finish(core_finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: finish drops lo_at cycles after start and rises hi_at cycles after (0 = never).
    always @(posedge clk) begin
        if (core_start) begin
            mcnt <= 1;
            if (lo_at == 1) core_finish <= 1'b0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt + 1;
            if (mcnt == lo_at - 1) core_finish <= 1'b0;
            if (hi_at != 0 && mcnt == hi_at - 1) begin
                core_finish  <= 1'b1;
                core_msg_out <= core_msg_in ^ FF;
                mcnt         <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_grant(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("grant_seen", 256'(at >= 0), 256'(1));
    endtask

    task automatic wait_rsp(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) viol++;
            if (rsp_valid != 2'b00) begin
                at = cyc;
                break;
            end
        end
        chk("rsp_seen", 256'(at >= 0), 256'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, 256'({req_ready, rsp_valid, rsp_err, core_reset, core_start, core_mode}), '0);
        chk({tag, "_rsp_msg"}, rsp_msg, '0);
        chk({tag, "_core_msg"}, core_msg_in, '0);
    endtask

    task automatic quiet(input string tag, input int n);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (core_start || rsp_valid != 2'b00) hits++;
        end
        chk(tag, 256'(hits), '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, tr, tg, prev_h, stable;
        logic [W-1:0] held;
        logic [1:0] exp;

        reset = 1'b1; req_valid = '0; req_mode = '0; req_msg = '0; rsp_ready = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single encrypt job from requester 0
        req_mode = 2'b01; req_msg[W-1:0] = M0; req_valid = 2'b01;
        wait_grant(5, t0);
        chk("t1_grant", 256'(req_ready), 256'(2'b01));
        @(negedge clk); req_valid = '0;
        chk("t1_core_reset", 256'(core_reset), 256'(1));
        chk("t1_core_mode", 256'(core_mode), 256'(1));
        chk("t1_core_msg", core_msg_in, M0);
        repeat (100) @(negedge clk);
        chk("t1_start_early", 256'(core_start), '0);
        @(negedge clk);
        chk("t1_start", 256'(core_start), 256'(1));
        wait_rsp(200, tr);
        chk("t1_latency", 256'(tr - t0), 256'(123));
        chk("t1_rsp_valid", 256'(rsp_valid), 256'(2'b01));
        chk("t1_rsp_msg", rsp_msg, 256'h48656c6c6f20576f726c64de);
        chk("t1_rsp_err", 256'(rsp_err), '0);
        rsp_ready = 2'b01;
        @(negedge clk); rsp_ready = '0;
        chk("t1_rsp_drop", 256'(rsp_valid), '0);

        // Contention after reset: grants alternate 0,1,0,1
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        req_msg = {M1, M0}; req_mode = 2'b01; rsp_ready = 2'b11; req_valid = 2'b11;
        viol = 0; prev_h = 0;
        for (int j = 0; j < 4; j++) begin
            exp = (j % 2 == 1) ? 2'b10 : 2'b01;
            wait_grant(10, tg);
            chk("ct_grant", 256'(req_ready), 256'(exp));
            if (j > 0) chk("ct_gap", 256'(tg - prev_h), 256'(1));
            wait_rsp(300, tr);
            chk("ct_rsp_valid", 256'(rsp_valid), 256'(exp));
            chk("ct_rsp_msg", rsp_msg, ((j % 2 == 1) ? M1 : M0) ^ FF);
            prev_h = tr;
        end
        req_valid = '0;
        @(negedge clk); rsp_ready = '0;
        chk("ct_ready_busy", 256'(viol), '0);

        // Backpressure on requester 1 while requester 0 waits
        req_msg[2*W-1:W] = M2; req_valid = 2'b10; rsp_ready = 2'b01;
        wait_grant(5, t0);
        chk("bp_grant", 256'(req_ready), 256'(2'b10));
        @(negedge clk); req_valid = 2'b11;
        viol = 0;
        wait_rsp(300, tr);
        chk("bp_rsp_valid", 256'(rsp_valid), 256'(2'b10));
        chk("bp_rsp_msg", rsp_msg, M2 ^ FF);
        held = rsp_msg;
        stable = 0;
        repeat (50) begin
            @(negedge clk);
            if (rsp_valid == 2'b10 && rsp_msg == held && !rsp_err && req_ready == 2'b00) stable++;
        end
        chk("bp_stable", 256'(stable), 256'(50));
        chk("bp_ready_busy", 256'(viol), '0);
        rsp_ready = 2'b10;
        @(negedge clk); rsp_ready = 2'b01;
        #1;
        chk("bp_next_grant", 256'(req_ready), 256'(2'b01));
        chk("bp_rsp_drop", 256'(rsp_valid), '0);
        @(negedge clk); req_valid = '0;
        wait_rsp(300, tr);
        chk("bp_job0_msg", rsp_msg, M0 ^ FF);
        @(negedge clk); rsp_ready = '0;

        // Stale finish held high through START
        lo_at = 11; hi_at = 16;
        req_valid = 2'b01; rsp_ready = 2'b01;
        wait_grant(5, t0);
        @(negedge clk); req_valid = '0;
        wait_rsp(300, tr);
        chk("st_latency", 256'(tr - t0), 256'(119));
        chk("st_rsp_err", 256'(rsp_err), '0);
        @(negedge clk); rsp_ready = '0;

        // Timeout: finish never rises
        lo_at = 1; hi_at = 0;
        req_valid = 2'b01; rsp_ready = 2'b01;
        wait_grant(5, t0);
        @(negedge clk); req_valid = '0;
        wait_rsp(300, tr);
        chk("to_latency", 256'(tr - t0), 256'(167));
        chk("to_rsp_err", 256'(rsp_err), 256'(1));
        chk("to_rsp_msg", rsp_msg, '0);
        @(negedge clk); rsp_ready = '0;

        // Reset during SETUP
        lo_at = 1; hi_at = 20;
        req_valid = 2'b01;
        wait_grant(5, t0);
        @(negedge clk); req_valid = '0;
        repeat (48) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_setup");
        reset = 1'b0;
        quiet("rst_setup_quiet", 150);

        // Reset during WAIT
        lo_at = 1; hi_at = 0;
        req_valid = 2'b01;
        wait_grant(5, t0);
        @(negedge clk); req_valid = '0;
        repeat (118) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_wait");
        reset = 1'b0;
        quiet("rst_wait_quiet", 100);
        req_valid = 2'b11;
        #1;
        chk("rst_priority", 256'(req_ready), 256'(2'b01));
        req_valid = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
